// File: rtl/bcd_seq_converter_if.sv
// bcd_seq_converter_if: operand request and BCD result bundle for the sequential converter
interface bcd_seq_converter_if #(
  parameter int W = 16,
  parameter int D = 5
);
  logic                       start;
  logic                       signed_mode;
  logic [W-1:0]               bin;
  logic                       ready;
  logic                       busy;
  logic                       done;
  logic                       sign;
  logic [4*D-1:0]             bcd;
  logic [$clog2(D+1)-1:0]     ndigits;
  modport master (
    output start, signed_mode, bin,
    input  ready, busy, done, sign, bcd, ndigits
  );
  modport slave (
    input  start, signed_mode, bin,
    output ready, busy, done, sign, bcd, ndigits
  );
endinterface

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: one-bit-per-clock double-dabble binary to sign/magnitude BCD
module bcd_seq_converter #(
  parameter int W = 16,
  parameter int D = 5
) (
  input logic                clk,
  input logic                rst,
  bcd_seq_converter_if.slave io
);
  localparam int CW = $clog2(W + 1);
  localparam int NW = $clog2(D + 1);
  function automatic logic [127:0] pow10(int n);
    logic [127:0] r;
    r = 128'd1;
    for (int i = 0; i < n; i++) r = r * 128'd10;
    return r;
  endfunction
  if (pow10(D) <= (128'd1 << W)) begin : g_chk
    $error("bcd_seq_converter: D digits cannot hold every W-bit magnitude");
  end
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   mag_q, mag_d;
  logic [4*D-1:0] dig_q, dig_d, adj, shifted, bcd_q, bcd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NW-1:0]  nd_q, nd_d, nd;
  logic           s_q, s_d, sign_q, sign_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    nd_d    = nd_q;
    done_d  = 1'b0;
    adj     = dig_q;
    for (int i = 0; i < D; i++)
      adj[4*i+:4] = dig_q[4*i+:4] >= 4'd5 ? dig_q[4*i+:4] + 4'd3 : dig_q[4*i+:4];
    shifted = {adj[4*D-2:0], mag_q[W-1]};
    nd      = NW'(1);
    for (int i = 0; i < D; i++)
      if (shifted[4*i+:4] != 4'd0) nd = NW'(i + 1);
    if (state_q == IDLE) begin
      if (io.start) begin
        state_d = SHIFT;
        s_d     = io.signed_mode & io.bin[W-1];
        mag_d   = s_d ? ~io.bin + 1'b1 : io.bin;
        dig_d   = '0;
        cnt_d   = CW'(W);
      end
    end else begin
      dig_d = shifted;
      mag_d = mag_q << 1;
      cnt_d = cnt_q - 1'b1;
      // Last iteration publishes the freshly shifted digits directly so done lands in cycle W+1.
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        bcd_d   = shifted;
        sign_d  = s_q;
        nd_d    = nd;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      nd_q    <= NW'(1);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      nd_q    <= nd_d;
      done_q  <= done_d;
    end
  end
  assign io.ready   = state_q == IDLE;
  assign io.busy    = state_q != IDLE;
  assign io.done    = done_q;
  assign io.sign    = sign_q;
  assign io.bcd     = bcd_q;
  assign io.ndigits = nd_q;
endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb_bcd_seq_converter: random and directed checks against an arithmetic reference model
module tb_bcd_seq_converter;
  localparam int W = 16;
  localparam int D = 5;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  bcd_seq_converter_if #(.W(W), .D(D)) io ();
  bcd_seq_converter #(.W(W), .D(D)) dut (.clk(clk), .rst(rst), .io(io));
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_sign = 1'b0;
  int m_left = 0;
  logic [4*D-1:0] m_bcd = '0;
  int m_nd = 1;
  bit p_sign;
  logic [4*D-1:0] p_bcd;
  int p_nd;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  task automatic model_convert(input logic [W-1:0] b, input bit sm,
                               output bit sg, output logic [4*D-1:0] dg, output int nd);
    longint v, mag;
    v   = (sm && b[W-1]) ? longint'(b) - (longint'(1) << W) : longint'(b);
    sg  = v < 0;
    mag = sg ? -v : v;
    dg  = '0;
    nd  = 1;
    for (int i = 0; i < D; i++) begin
      dg[4*i+:4] = 4'(mag % 10);
      if (mag % 10 != 0) nd = i + 1;
      mag = mag / 10;
    end
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_sign = 1'b0; m_bcd = '0; m_nd = 1;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_sign = p_sign; m_bcd = p_bcd; m_nd = p_nd;
        end
      end else if (io.start) begin
        model_convert(io.bin, io.signed_mode, p_sign, p_bcd, p_nd);
        m_busy = 1'b1;
        m_left = W;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("ready", io.ready, !m_busy);
    chk("busy", io.busy, m_busy);
    chk("done", io.done, m_done);
    chk("sign", io.sign, m_sign);
    chk("bcd", io.bcd, m_bcd);
    chk("ndigits", io.ndigits, m_nd);
  end
  task automatic go(input logic [W-1:0] b, input bit sm, output int c0);
    @(negedge clk); #1;
    io.start = 1'b1; io.bin = b; io.signed_mode = sm;
    c0 = cyc;
    @(negedge clk); #1;
    io.start = 1'b0;
  endtask
  task automatic wait_done(output int at);
    at = -1;
    for (int k = 0; k < 3 * W; k++) begin
      @(negedge clk);
      if (io.done) begin at = cyc; break; end
    end
    if (at < 0) chk("done_timeout", 0, 1);
  endtask
  task automatic run(input logic [W-1:0] b, input bit sm, input logic [4*D-1:0] eb,
                     input bit es, input int en);
    int c0, at;
    go(b, sm, c0);
    wait_done(at);
    chk("latency", at - c0, W + 1);
    chk("lit_bcd", io.bcd, eb);
    chk("lit_sign", io.sign, es);
    chk("lit_nd", io.ndigits, en);
  endtask
  initial begin
    int c0, at, nd_cnt;
    logic [4*D-1:0] got;
    int ats[3];
    int k;
    rst = 1'b1; io.start = 1'b0; io.bin = '0; io.signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", io.ready, 1);
    chk("rst_busy", io.busy, 0);
    chk("rst_done", io.done, 0);
    chk("rst_bcd", io.bcd, 0);
    chk("rst_nd", io.ndigits, 1);
    chk_en = 1'b1;
    #1 rst = 1'b0;
    run(16'hFFFF, 1'b0, 20'h65535, 1'b0, 5);
    run(16'hFFFF, 1'b1, 20'h00001, 1'b1, 1);
    run(16'h8000, 1'b1, 20'h32768, 1'b1, 5);
    run(16'h7FFF, 1'b1, 20'h32767, 1'b0, 5);
    run(16'h8000, 1'b0, 20'h32768, 1'b0, 5);
    run(16'd0, 1'b0, 20'h00000, 1'b0, 1);
    run(16'd0, 1'b1, 20'h00000, 1'b0, 1);
    run(16'd1000, 1'b0, 20'h01000, 1'b0, 4);
    go(16'd123, 1'b0, c0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    io.start = 1'b1; io.bin = 16'd5;
    @(negedge clk); #1;
    io.start = 1'b0;
    nd_cnt = 0; got = '0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (io.done) begin nd_cnt++; got = io.bcd; end
    end
    chk("ignore_done_count", nd_cnt, 1);
    chk("ignore_bcd", got, 20'h00123);
    @(negedge clk); #1;
    io.start = 1'b1; io.bin = 16'd42; io.signed_mode = 1'b0;
    c0 = cyc; k = 0;
    for (int i = 0; i < 4 * (W + 1) && k < 3; i++) begin
      @(negedge clk);
      if (io.done) begin
        ats[k] = cyc - c0;
        chk("held_bcd", io.bcd, 20'h00042);
        k++;
      end
    end
    #1 io.start = 1'b0;
    chk("held_dones", k, 3);
    for (int i = 0; i < k; i++) chk("held_cycle", ats[i], (W + 1) * (i + 1));
    repeat (W + 2) @(negedge clk);
    go(16'd9999, 1'b0, c0);
    repeat (7) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", io.ready, 1);
    chk("abort_bcd", io.bcd, 0);
    chk("abort_nd", io.ndigits, 1);
    #1 rst = 1'b0;
    nd_cnt = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (io.done) nd_cnt++;
    end
    chk("abort_no_done", nd_cnt, 0);
    run(16'd9999, 1'b0, 20'h09999, 1'b0, 4);
    for (int i = 0; i < 4000; i++) begin
      int sel;
      @(negedge clk); #1;
      sel = $urandom_range(0, 7);
      io.start = ($urandom_range(0, 2) == 0);
      io.signed_mode = $urandom_range(0, 1);
      io.bin = sel == 0 ? 16'h0000 : sel == 1 ? 16'h8000 : sel == 2 ? 16'hFFFF :
               sel == 3 ? 16'h7FFF : W'($urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    #1 rst = 1'b0; io.start = 1'b0;
    repeat (W + 3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_err);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
- Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Accepts unsigned or two's-complement operands, e.g. signed products from the signed serial-parallel multiplier, selected per conversion.
- Produces sign, magnitude BCD digits and a significant-digit count for display drivers.
- Replaces the combinational converter where a W-deep add-3 tree is too large or too slow.

Parameters:
- W, 16, input operand width (W >= 4).
- D, 5, number of BCD output digits. Constraint: 10^D > 2^W; an elaboration-time check errors otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion; sampled only when ready=1.
- signed_mode  in  1  1 = treat bin as two's complement; 0 = unsigned. Latched with start.
- bin  in  W  operand; latched with start.
- ready  out  1  1 when idle and able to accept start.
- busy  out  1  1 while a conversion is in progress (exact complement of ready).
- done  out  1  one-cycle pulse marking new valid results.
- sign  out  1  1 = result negative.
- bcd  out  4*D  digits {d[D-1],...,d[0]}; d[0] is the ones digit.
- ndigits  out  clog2(D+1)  count of significant digits, 1..D (zero reports 1).

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE.
  - ready=1, busy=0, done=0, sign=0, bcd=0, ndigits=1.
  - Internal shift and digit registers are cleared.
  - Reset mid-conversion aborts it: no done pulse, and outputs take their reset values.
- FSM states: IDLE, SHIFT.
- IDLE:
  - ready=1.
  - On start=1, latch the sign and magnitude and go to SHIFT. Clear the working digit register and set the bit counter to W.
  - Sign/magnitude latch: s = signed_mode & bin[W-1]; mag = s ? (~bin + 1) : bin, computed in W bits.
  - Most-negative value 2^(W-1) yields mag = 2^(W-1), correct as unsigned W bits, with s=1.
- SHIFT, one iteration per cycle for exactly W cycles. Each iteration:
  - Every working digit >= 5 gets +3, evaluated on the pre-shift value, all digits in parallel.
  - Then {digits, mag} shifts left by 1; the MSB of mag enters d[0] bit 0.
  - Counter decrements.
  - After the W-th iteration: register the working digits to bcd and s to sign, compute ndigits, pulse done for one cycle, return to IDLE.
- Latency: start sampled in cycle 0; done=1 and new outputs are visible in cycle W+1. Throughput is one result per W+1 cycles.
- Back-to-back: the done cycle is an IDLE cycle (ready=1), so a start sampled in that cycle is accepted and the next done lands W+1 cycles later.
- start while busy is ignored: no effect on state, operands or results.
- Outputs sign, bcd and ndigits hold their last completed values until the next done. They do not change during SHIFT.
- ndigits = 1 + index of the highest nonzero digit, or 1 if all digits are zero.
- Negative zero cannot occur: sign=0 whenever mag=0.
- With signed_mode=0, bin[W-1] is a magnitude bit and sign is always 0.

Test Plan:
- W=16, D=5, unsigned bin=16'hFFFF, start in cycle 0 -> done only in cycle 17; bcd=20'h65535, sign=0, ndigits=5; ready=0 and busy=1 in cycles 1-16.
- Signed bin=16'hFFFF -> sign=1, bcd=20'h00001, ndigits=1. Signed bin=16'h8000 -> sign=1, bcd=20'h32768, ndigits=5. Signed bin=16'h7FFF -> sign=0, bcd=20'h32767.
- bin=0, either mode -> sign=0, bcd=0, ndigits=1. Unsigned bin=1000 -> bcd=20'h01000, ndigits=4.
- start pulsed with bin=5 in cycle 3 of a conversion of bin=123 -> single done with bcd=20'h00123; no second done.
- start held high continuously with bin=42 -> done in cycles 17, 34, 51; each result is 20'h00042.
- rst asserted in cycle 8 of a conversion -> next cycle ready=1, bcd=0, ndigits=1; no done pulse. A new start then converts normally.
